// File: rtl/robo_wall_follower.sv
// Left-hand wall-following controller: one forward/turn/remove command per clock, halts on exit.
// Define ROBO_STEP_COUNT_EN to add a saturating step_count output counting forward pulses.
module robo_wall_follower #(
    parameter int unsigned MAX_REMOVE    = 4,
    parameter int unsigned UNDER_CONFIRM = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        head,
    input  logic        left,
    input  logic        under,
    input  logic        barrier,
    output logic        forward,
    output logic        turn,
`ifdef ROBO_STEP_COUNT_EN
    output logic        remove,
    output logic [15:0] step_count
`else
    output logic        remove
`endif
);

    typedef enum logic [2:0] {
        StSearch,
        StFollow,
        StAdvance,
        StRotate,
        StRemove,
        StDone
    } state_e;

    localparam logic [2:0] MaxRem       = 3'(MAX_REMOVE);
    localparam logic [2:0] UnderConfirm = 3'(UNDER_CONFIRM);

    state_e     state_q, state_d;
    state_e     ret_state_q, ret_state_d;
    logic [1:0] turn_cnt_q, turn_cnt_d;
    logic [2:0] rem_cnt_q, rem_cnt_d;
    logic [2:0] under_cnt_q, under_cnt_d;
    logic       fwd_d, turn_d, rem_d;

    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        turn_cnt_d  = turn_cnt_q;
        rem_cnt_d   = rem_cnt_q;
        fwd_d       = 1'b0;
        turn_d      = 1'b0;
        rem_d       = 1'b0;

        if (!under) begin
            under_cnt_d = 3'd0;
        end else if (under_cnt_q == 3'd7) begin
            under_cnt_d = 3'd7;
        end else begin
            under_cnt_d = under_cnt_q + 3'd1;
        end

        // A confirmed exit overrides every other rule this cycle.
        if (state_q != StDone && under_cnt_d >= UnderConfirm) begin
            state_d = StDone;
        end else begin
            unique case (state_q)
                StSearch: begin
                    if (barrier) begin
                        ret_state_d = StSearch;
                        state_d     = StRemove;
                    end else if (!head) begin
                        fwd_d = 1'b1;
                    end else begin
                        turn_d     = 1'b1;
                        turn_cnt_d = 2'd3;
                        state_d    = StRotate;
                    end
                end
                StFollow: begin
                    if (!left) begin
                        turn_d  = 1'b1;
                        state_d = StAdvance;
                    end else if (barrier) begin
                        ret_state_d = StFollow;
                        state_d     = StRemove;
                    end else if (!head) begin
                        fwd_d = 1'b1;
                    end else begin
                        turn_d     = 1'b1;
                        turn_cnt_d = 2'd3;
                        state_d    = StRotate;
                    end
                end
                StAdvance: begin
                    if (barrier) begin
                        ret_state_d = StAdvance;
                        state_d     = StRemove;
                    end else if (!head) begin
                        fwd_d   = 1'b1;
                        state_d = StFollow;
                    end else begin
                        state_d = StFollow;
                    end
                end
                StRotate: begin
                    // The entry edge issues the first of three turns; count 3 -> 2 -> 1.
                    turn_d = 1'b1;
                    if (turn_cnt_q <= 2'd2) begin
                        turn_cnt_d = 2'd0;
                        state_d    = StFollow;
                    end else begin
                        turn_cnt_d = turn_cnt_q - 2'd1;
                    end
                end
                StRemove: begin
                    if (!barrier) begin
                        rem_cnt_d = 3'd0;
                        state_d   = ret_state_q;
                    end else if (rem_cnt_q < MaxRem) begin
                        rem_d     = 1'b1;
                        rem_cnt_d = rem_cnt_q + 3'd1;
                    end else begin
                        rem_cnt_d  = 3'd0;
                        turn_d     = 1'b1;
                        turn_cnt_d = 2'd3;
                        state_d    = StRotate;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StSearch;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StSearch;
            ret_state_q <= StSearch;
            turn_cnt_q  <= 2'd0;
            rem_cnt_q   <= 3'd0;
            under_cnt_q <= 3'd0;
            forward     <= 1'b0;
            turn        <= 1'b0;
            remove      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            turn_cnt_q  <= turn_cnt_d;
            rem_cnt_q   <= rem_cnt_d;
            under_cnt_q <= under_cnt_d;
            forward     <= fwd_d;
            turn        <= turn_d;
            remove      <= rem_d;
        end
    end

`ifdef ROBO_STEP_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step_count <= 16'd0;
        end else if (fwd_d && step_count != 16'hFFFF) begin
            step_count <= step_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/robo_wall_follower.md
Name: robo_wall_follower

Overview:
- Synthesizable controller for the collector robot; it is the counterpart of the map/world model that drives the sensors.
- Consumes the four sensor bits (head, left, under, barrier) and issues one movement command per clock: forward, turn, or remove.
- Implements left-hand wall following using only left turns. A right turn is three consecutive left turns.
- Clears rubble ahead with repeated remove pulses and halts when the exit (under) is confirmed.

Parameters:
- MAX_REMOVE, 4, remove pulses issued on one obstacle before it is treated as a wall.
- UNDER_CONFIRM, 2, consecutive sampled cycles with under=1 required to enter DONE (range 1..7).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low (reset=0 resets immediately; released synchronously by the environment).
- head  input  1  wall directly ahead.
- left  input  1  wall on the robot's left.
- under  input  1  robot is standing on the exit cell.
- barrier  input  1  removable rubble directly ahead.
- forward  output  1  registered command: advance one cell.
- turn  output  1  registered command: rotate 90 degrees left.
- remove  output  1  registered command: one removal stroke on the rubble ahead.

Behaviour:
- Reset (reset=0, asynchronous):
  - forward=turn=remove=0, state=SEARCH.
  - turn_cnt=0, rem_cnt=0, under_cnt=0, ret_state=SEARCH.
- Outputs:
  - Registered; at most one of forward/turn/remove is high in any cycle.
  - Each command is decided from the inputs sampled at the same rising edge, so latency is 1 cycle from input change to command.
  - A command is a 1-cycle pulse. A cycle with all outputs 0 is a no-op.
- under debounce:
  - under_cnt increments (saturating) while under=1 and clears on under=0.
  - Reaching UNDER_CONFIRM forces DONE from any state, overriding all other rules in that cycle.
- SEARCH (no wall acquired):
  - barrier=1: ret_state=SEARCH, go to REMOVE, issue no command this cycle.
  - else head=0: forward.
  - else head=1: ROTATE with turn_cnt=3.
- FOLLOW (wall on left), rules in priority order:
  - left=0: turn, go to ADVANCE.
  - barrier=1: ret_state=FOLLOW, go to REMOVE, no command.
  - head=0: forward.
  - head=1: ROTATE with turn_cnt=3.
- ADVANCE (just turned into an opening):
  - barrier=1: ret_state=ADVANCE, go to REMOVE, no command.
  - head=0: forward, go to FOLLOW.
  - head=1: no-op, go to FOLLOW.
- ROTATE:
  - Issue turn and decrement turn_cnt every cycle.
  - When turn_cnt reaches 1 the current turn is the last; the next state is FOLLOW.
  - Sensors other than under are ignored while rotating.
- REMOVE:
  - barrier=1 and rem_cnt<MAX_REMOVE: remove, rem_cnt+1.
  - barrier=0: no-op, rem_cnt=0, return to ret_state.
  - rem_cnt==MAX_REMOVE with barrier still 1: rem_cnt=0, ROTATE with turn_cnt=3 (obstacle treated as a wall).
- DONE:
  - All outputs 0; the block stays in DONE until reset.
- Simultaneous events:
  - under confirmation beats everything.
  - barrier beats head.
  - In FOLLOW, left=0 beats barrier/head.
- Widths: turn_cnt is 2 bits; rem_cnt and under_cnt are 3 bits. Counters never wrap.
- Reset asserted mid-ROTATE or mid-REMOVE aborts immediately; the next post-reset command is decided from SEARCH.

Optional Feature:
- Macro: ROBO_STEP_COUNT_EN.
- Defined:
  - Adds output port step_count [15:0], reset to 0.
  - Increments once per forward pulse and saturates at 16'hFFFF.
  - Frozen in DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Open field after reset (head=0, left=0, barrier=0, under=0), 5 cycles -> forward=1 on each of the 5 edges, turn=remove=0.
- SEARCH with head=1, left=0 -> turn pulses on 3 consecutive cycles. Then set left=1, head=0 -> forward on the 4th cycle (state FOLLOW).
- FOLLOW with barrier=1 held for 2 remove cycles, then 0 -> no-op, remove, remove, no-op, then forward with head=0, left=1.
- barrier held at 1 in SEARCH with MAX_REMOVE=4 -> no-op, exactly 4 remove pulses, then 3 turn pulses.
- under=1 for 1 cycle then 0 -> no DONE, commands continue. under=1 for 2 cycles -> all outputs 0 permanently. Assert reset=0 -> returns to SEARCH and forward resumes.
- With ROBO_STEP_COUNT_EN: 10 forward pulses -> step_count=10. Reset=0 mid-ROTATE -> step_count=0 and outputs 0 within the same cycle (asynchronous).
